// File: rtl/dac_counter_pkg.sv
// Shared audio constants: DAC code width, terminal code and the code type.
package dac_counter_pkg;

  localparam int DAC_WIDTH = 8;
  localparam int DAC_MAX   = 255;

  typedef logic [DAC_WIDTH-1:0] dac_code_t;

endpackage

// File: rtl/dac_counter.sv
// Sample-index counter for the DAC path: advances on at_max, wraps after MAX_COUNT.
// Latency 1 cycle, registered output; no backpressure, at_max is sampled every edge.
module dac_counter
  import dac_counter_pkg::*;
#(
  parameter int WIDTH     = DAC_WIDTH,
  parameter int MAX_COUNT = DAC_MAX
) (
  input  logic             clk,
  input  logic             nRst,
  input  logic             at_max,
  output logic [WIDTH-1:0] dacCount
);

  if (WIDTH < 1 || MAX_COUNT < 0 || MAX_COUNT > (2 ** WIDTH) - 1) begin : g_bad_params
    $error("dac_counter: MAX_COUNT must fit in WIDTH bits and WIDTH must be >= 1");
  end

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MAX_COUNT);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (at_max) begin
      if (count_q == MAX_VAL) count_d = '0;
      else                    count_d = count_q + 1'b1;
    end
  end

  // nRst is active-high despite its name; it takes priority over at_max.
  always_ff @(posedge clk) begin
    if (nRst) count_q <= '0;
    else      count_q <= count_d;
  end

  assign dacCount = count_q;

endmodule

// File: tb/tb_dac_counter.sv
// Directed bench for dac_counter: default 8-bit wrap and a MAX_COUNT=9 instance.
module tb_dac_counter;
  import dac_counter_pkg::*;

  logic      tb_clk;
  logic      rst_a, adv_a;
  logic      rst_b, adv_b;
  dac_code_t cnt_a;
  logic [3:0] cnt_b;

  int n_cmp;
  int n_bad;

  dac_counter u_dut_a (
    .clk      (tb_clk),
    .nRst     (rst_a),
    .at_max   (adv_a),
    .dacCount (cnt_a)
  );

  dac_counter #(.WIDTH(4), .MAX_COUNT(9)) u_dut_b (
    .clk      (tb_clk),
    .nRst     (rst_b),
    .at_max   (adv_b),
    .dacCount (cnt_b)
  );

  initial tb_clk = 1'b0;
  always #5 tb_clk = ~tb_clk;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Wait for the next rising edge, then settle before sampling.
  task automatic tick();
    @(posedge tb_clk);
    #1;
  endtask

  task automatic run_a(input int edges, input logic adv);
    adv_a = adv;
    for (int i = 0; i < edges; i++) tick();
  endtask

  task automatic reset_a();
    rst_a = 1'b1;
    adv_a = 1'b0;
    tick();
    rst_a = 1'b0;
  endtask

  initial begin
    bit seen9;
    bit seen10;
    n_cmp = 0;
    n_bad = 0;
    rst_a = 1'b1;
    adv_a = 1'b0;
    rst_b = 1'b1;
    adv_b = 1'b0;

    // Reset hold with at_max toggling
    adv_a = 1'b1; tick(); check_val("rst_hold0", int'(cnt_a), 0);
    adv_a = 1'b0; tick(); check_val("rst_hold1", int'(cnt_a), 0);
    adv_a = 1'b1; tick(); check_val("rst_hold2", int'(cnt_a), 0);

    // Release: first advancing edge gives 1, 25 edges gives 25
    rst_a = 1'b0;
    run_a(1, 1'b1);  check_val("release_first", int'(cnt_a), 1);
    run_a(24, 1'b1); check_val("count25", int'(cnt_a), 25);
    run_a(5, 1'b0);  check_val("hold25", int'(cnt_a), 25);

    // Wrap at 255 -> 0 on the same edge
    reset_a();
    check_val("reset_before_wrap", int'(cnt_a), 0);
    run_a(255, 1'b1); check_val("reach255", int'(cnt_a), 255);
    run_a(1, 1'b1);   check_val("wrap256", int'(cnt_a), 0);

    reset_a();
    run_a(1000, 1'b1); check_val("count1000", int'(cnt_a), 232);

    // Reset mid-count with at_max high
    reset_a();
    run_a(100, 1'b1); check_val("count100", int'(cnt_a), 100);
    rst_a = 1'b1; adv_a = 1'b1; tick();
    check_val("rst_mid", int'(cnt_a), 0);
    rst_a = 1'b0; tick();
    check_val("rst_mid_release", int'(cnt_a), 1);

    // Gapped strobe, 1-in-4
    reset_a();
    for (int i = 0; i < 40; i++) begin
      adv_a = (i % 4 == 0);
      tick();
    end
    check_val("gapped40", int'(cnt_a), 10);

    // MAX_COUNT = 9 instance
    rst_b = 1'b1; tick();
    check_val("b_reset", int'(cnt_b), 0);
    rst_b = 1'b0;
    adv_b = 1'b1;
    seen9  = 1'b0;
    seen10 = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (cnt_b == 4'd9)  seen9  = 1'b1;
      if (cnt_b == 4'd10) seen10 = 1'b1;
      check_val($sformatf("b_step%0d", i + 1), int'(cnt_b), (i + 1) % 10);
    end
    check_val("b_final", int'(cnt_b), 2);
    check_val("b_seen9", int'(seen9), 1);
    check_val("b_seen10", int'(seen10), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
